// File: rtl/prog_counter.sv
// Programmable up/down counter. It has a run-time direction, a writable limit,
// and wrap or saturate behaviour. It provides a combinational carry for cascading stages.
module prog_counter #(
    parameter int COUNT_WIDTH   = 5,
    parameter int COUNT_LIMIT   = 10,
    parameter int UP_DOWN_COUNT = 1,
    parameter int SATURATE      = 0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   clear,
    input  logic                   enable,
    input  logic                   load,
    input  logic [COUNT_WIDTH-1:0] load_value,
    input  logic                   dir,
    input  logic                   limit_wr,
    input  logic [COUNT_WIDTH-1:0] limit_in,
    output logic [COUNT_WIDTH-1:0] count,
    output logic [COUNT_WIDTH-1:0] limit,
    output logic                   at_term,
    output logic                   carry,
    output logic                   wrap
);

    localparam logic [COUNT_WIDTH-1:0] RST_LIMIT = COUNT_LIMIT[COUNT_WIDTH-1:0];
    localparam logic [COUNT_WIDTH-1:0] RST_COUNT = (UP_DOWN_COUNT != 0) ? '0 : RST_LIMIT;
    localparam logic                   SAT       = (SATURATE != 0);

    logic [COUNT_WIDTH-1:0] count_q, count_d;
    logic [COUNT_WIDTH-1:0] limit_q, limit_d;
    logic                   wrap_q, wrap_d;
    logic [COUNT_WIDTH-1:0] term_val, start_val;

    always_comb begin
        term_val  = dir ? limit_q : '0;
        start_val = dir ? '0 : limit_q;
        at_term   = (count_q == term_val);
        carry     = enable & at_term & ~SAT;
    end

    // Every count decision compares against the stored limit, even on an edge that rewrites it.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clear) begin
            count_d = start_val;
        end else if (load) begin
            count_d = (load_value > limit_q) ? limit_q : load_value;
        end else if (enable) begin
            if (dir) begin
                if (count_q < limit_q) begin
                    count_d = count_q + 1'b1;
                end else if (SAT) begin
                    count_d = limit_q;
                end else begin
                    count_d = '0;
                    wrap_d  = 1'b1;
                end
            end else begin
                if (count_q > limit_q) begin
                    count_d = limit_q;
                end else if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else if (!SAT) begin
                    count_d = limit_q;
                    wrap_d  = 1'b1;
                end
            end
        end
    end

    always_comb begin
        limit_d = limit_wr ? limit_in : limit_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RST_COUNT;
            limit_q <= RST_LIMIT;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            limit_q <= limit_d;
            wrap_q  <= wrap_d;
        end
    end

    assign count = count_q;
    assign limit = limit_q;
    assign wrap  = wrap_q;

endmodule

// File: doc/prog_counter.md
# prog_counter

Parametrised, run-time programmable successor to the team's fixed up/down counter, used for pixel, line and frame-slot counting in the stereo feed encryption pipeline. It adds:

- enable and synchronous clear
- parallel load
- run-time direction select
- a writable limit register
- wrap or saturate mode
- a registered wrap pulse and a combinational carry for cascading counters, e.g. pixel → line

## Interface
- COUNT_WIDTH, 5, width of count, limit and load paths
- COUNT_LIMIT, 10, limit register value after reset; must fit in COUNT_WIDTH
- UP_DOWN_COUNT, 1, reset count selector: 1 → count resets to 0, 0 → count resets to COUNT_LIMIT
- SATURATE, 0, 0 = wrap at terminal value, 1 = hold at terminal value

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear; loads the direction's start value
- enable  in  1  count-step qualifier
- load  in  1  synchronous parallel load
- load_value  in  COUNT_WIDTH  value for load
- dir  in  1  1 = up, 0 = down
- limit_wr  in  1  write limit register
- limit_in  in  COUNT_WIDTH  new limit
- count  out  COUNT_WIDTH  current count, registered
- limit  out  COUNT_WIDTH  current limit register
- at_term  out  1  combinational; count equals terminal value for current dir
- carry  out  1  combinational; enable & at_term & ~SATURATE
- wrap  out  1  registered one-cycle pulse: a wrap occurred on the previous edge

## Operation
- **Reset (reset_n low, asynchronous):**
  - count = 0 if UP_DOWN_COUNT=1, else COUNT_LIMIT
  - limit = COUNT_LIMIT
  - wrap = 0
- **Terminal value:** limit when dir=1; 0 when dir=0.
- **Start value:** 0 when dir=1; limit when dir=0.
- **Per-edge priority for count:** clear > load > enable step > hold.
  - clear: count ← start value; wrap ← 0.
  - load: count ← min(load_value, limit), compared against the stored (pre-write) limit; wrap ← 0.
  - enable, up:
    - count < limit: count+1
    - count ≥ limit: wrap to 0 with wrap ← 1, or hold at limit with wrap ← 0 if SATURATE
  - enable, down:
    - count > limit (limit lowered beneath count): count ← limit; no wrap
    - 0 < count ≤ limit: count−1
    - count == 0: wrap to limit with wrap ← 1, or hold 0 if SATURATE
  - Otherwise count holds and wrap ← 0.
- **Limit register:**
  - limit_wr writes limit_in independently of the count priority chain.
  - The new limit takes effect from the next cycle.
  - The same-edge count decision always uses the old limit.
- **limit = 0:** an enabled counter stays at 0 and pulses wrap every enabled cycle (wrap mode); saturate mode holds 0 with no wrap.
- **dir change:** may occur on any cycle and takes effect immediately on the next enabled edge. No restart is implied; count continues from its current value.
- **Arithmetic:** unsigned, modulo 2^COUNT_WIDTH internally. Out-of-range values are never produced, because every comparison is against limit.
- **Cascading:** the next stage's enable = this stage's carry.

## Timing
- All state changes occur on the rising clk edge, except reset.
- Reset assertion is immediate. Deassertion is synchronised by the system reset tree; no block-internal synchroniser.
- Latency:
  - enable/load/clear → count: 1 cycle
  - limit_wr → limit: 1 cycle
  - wrap: aligned with the count update
- at_term and carry are combinational from count, limit, dir and enable. They are valid in the same cycle, with no registered delay.
- Assertion of clear or load suppresses the step and the wrap pulse on that edge, even with enable high.
- Reset mid-count: count, limit and wrap return to reset values asynchronously; any pending limit_wr is lost.

## Test plan
- **Reset/up wrap:** reset_n low→high, defaults, dir=1, enable=1 for 12 cycles → count 0,1,…,10,0,1; wrap high exactly in the cycle count returns to 0; carry high while count=10.
- **Down with limit write:** dir=0, count=10; write limit_in=4 at count=7 → next edge uses old limit (count=6), following edge count=4, then 3,2,1,0,4; wrap asserted with the 0→4 step.
- **Saturate:** SATURATE=1, dir=1, count=8, enable held 5 cycles → 9,10,10,10,10; wrap never asserts; carry stays 0.
- **Priority:** enable=1, load=1 with load_value=25 and limit=10, clear=0 → count=10; same with clear=1 → count=0 (dir=1); wrap=0 in both cases.
- **Cascade:** two instances; stage-0 limit=3, stage-1 enable=stage-0 carry, 20 cycles → stage 1 increments once per 4 stage-0 cycles, aligned with stage-0 3→0.
- **Async reset mid-operation:** pulse reset_n low for 3 ns between edges at count=7, limit=4 → count=0 and limit=10 immediately; no glitch on wrap.
